reg_access_ctrl: RTL and testbench

REG_ACCESS_CTRL -- requirements
Module: reg_access_ctrl

---
 rtl/reg_access_ctrl.sv | 122 ++++++++++++
 tb/tb_reg_access_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_access_ctrl.sv
// Command-driven controller for an external register array: READ, WRITE, COPY and SWAP
// are sequenced through read/write states, with one buffered response per command.
module reg_access_ctrl #(
  parameter int m = 2,
  parameter int n = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         cmdValid,
  output logic         cmdReady,
  input  logic [1:0]   cmdOp,
  input  logic [m-1:0] cmdAddrA,
  input  logic [m-1:0] cmdAddrB,
  input  logic [n-1:0] cmdData,
  output logic         rspValid,
  input  logic         rspReady,
  output logic [n-1:0] rspData,
  output logic         regWriteEnable,
  output logic [m-1:0] regWriteAddr,
  output logic [n-1:0] regDataIn,
  output logic [m-1:0] regReadAddr,
  input  logic [n-1:0] regDataOut
);

  localparam logic [1:0] OP_READ  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;
  localparam logic [1:0] OP_SWAP  = 2'b11;

  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR_A, WR_B, RESP} stateT;

  stateT        state;
  stateT        nextState;
  logic [1:0]   opReg;
  logic [m-1:0] addrA;
  logic [m-1:0] addrB;
  logic [n-1:0] dataReg;
  logic [n-1:0] tmpA;
  logic [n-1:0] tmpB;
  logic         readyEn;

  // readyEn keeps cmdReady low while in reset and until the first edge after release
  assign cmdReady = (state == IDLE) && readyEn;

  always_comb begin
    nextState = state;
    case (state)
      IDLE: if (cmdValid && cmdReady) nextState = (cmdOp == OP_WRITE) ? WR_A : RD_A;
      RD_A: begin
        case (opReg)
          OP_COPY: nextState = WR_B;
          OP_SWAP: nextState = RD_B;
          default: nextState = RESP;
        endcase
      end
      RD_B:    nextState = WR_A;
      WR_A:    nextState = (opReg == OP_SWAP) ? WR_B : RESP;
      WR_B:    nextState = RESP;
      RESP:    if (rspValid && rspReady) nextState = IDLE;
      default: nextState = IDLE;
    endcase
  end

  // Array-side signals come only from registered state so they settle before the negedge write
  always_comb begin
    regWriteEnable = 1'b0;
    regWriteAddr   = '0;
    regDataIn      = '0;
    regReadAddr    = '0;
    case (state)
      RD_A: regReadAddr = addrA;
      RD_B: regReadAddr = addrB;
      WR_A: begin
        regWriteEnable = 1'b1;
        regWriteAddr   = addrA;
        regDataIn      = (opReg == OP_SWAP) ? tmpB : dataReg;
      end
      WR_B: begin
        regWriteEnable = 1'b1;
        regWriteAddr   = addrB;
        regDataIn      = tmpA;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state    <= IDLE;
      readyEn  <= 1'b0;
      opReg    <= OP_READ;
      addrA    <= '0;
      addrB    <= '0;
      dataReg  <= '0;
      tmpA     <= '0;
      tmpB     <= '0;
      rspValid <= 1'b0;
      rspData  <= '0;
    end else begin
      state   <= nextState;
      readyEn <= 1'b1;
      if (cmdValid && cmdReady) begin
        opReg   <= cmdOp;
        addrA   <= cmdAddrA;
        addrB   <= cmdAddrB;
        dataReg <= cmdData;
      end
      if (state == RD_A) tmpA <= regDataOut;
      if (state == RD_B) tmpB <= regDataOut;
      // Response is registered one edge into RESP and then held until the handshake
      if (state == RESP) begin
        if (rspValid && rspReady) begin
          rspValid <= 1'b0;
        end else begin
          rspValid <= 1'b1;
          rspData  <= (opReg == OP_WRITE) ? dataReg : tmpA;
        end
      end
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural 4x8 register array written on negedge.
module tb_reg_access_ctrl;

  logic       clk;
  logic       clr;
  logic       cmdValid;
  logic       cmdReady;
  logic [1:0] cmdOp;
  logic [1:0] cmdAddrA;
  logic [1:0] cmdAddrB;
  logic [7:0] cmdData;
  logic       rspValid;
  logic       rspReady;
  logic [7:0] rspData;
  logic       regWriteEnable;
  logic [1:0] regWriteAddr;
  logic [7:0] regDataIn;
  logic [1:0] regReadAddr;
  logic [7:0] regDataOut;

  logic [7:0] regs [4];
  int         writeCount;
  int         testCount;
  int         failCount;

  reg_access_ctrl #(.m(2), .n(8)) dut (
    .clk(clk), .clr(clr),
    .cmdValid(cmdValid), .cmdReady(cmdReady), .cmdOp(cmdOp),
    .cmdAddrA(cmdAddrA), .cmdAddrB(cmdAddrB), .cmdData(cmdData),
    .rspValid(rspValid), .rspReady(rspReady), .rspData(rspData),
    .regWriteEnable(regWriteEnable), .regWriteAddr(regWriteAddr),
    .regDataIn(regDataIn), .regReadAddr(regReadAddr), .regDataOut(regDataOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign regDataOut = regs[regReadAddr];

  always @(negedge clk) begin
    if (regWriteEnable === 1'b1) begin
      regs[regWriteAddr] <= regDataIn;
      writeCount <= writeCount + 1;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected) else begin
      failCount++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Issues one command, scrambles the inputs after accept, and checks latency/data/write count
  task automatic applyStimulus(input string tag, input logic [1:0] op, input logic [1:0] a,
                               input logic [1:0] b, input logic [7:0] d, input int expLat,
                               input logic [7:0] expData, input int expWrites);
    int lat;
    int w0;
    cmdValid = 1'b1;
    cmdOp    = op;
    cmdAddrA = a;
    cmdAddrB = b;
    cmdData  = d;
    checkOutput({tag, ".cmdReady"}, 32'(cmdReady), 32'd1);
    w0 = writeCount;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    cmdOp    = ~op;
    cmdAddrA = ~a;
    cmdAddrB = ~b;
    cmdData  = ~d;
    lat = 0;
    while (rspValid !== 1'b1 && lat < 12) begin
      @(posedge clk); #1;
      lat++;
    end
    checkOutput({tag, ".latency"}, 32'(lat), 32'(expLat));
    checkOutput({tag, ".rspData"}, 32'(rspData), 32'(expData));
    rspReady = 1'b1;
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput({tag, ".writes"}, 32'(writeCount - w0), 32'(expWrites));
    checkOutput({tag, ".rspValidDone"}, 32'(rspValid), 32'd0);
  endtask

  initial begin
    testCount  = 0;
    failCount  = 0;
    writeCount = 0;
    for (int i = 0; i < 4; i++) regs[i] = 8'h00;
    clr      = 1'b0;
    cmdValid = 1'b0;
    cmdOp    = 2'b00;
    cmdAddrA = 2'd0;
    cmdAddrB = 2'd0;
    cmdData  = 8'h00;
    rspReady = 1'b0;

    #2;
    checkOutput("reset.cmdReady", 32'(cmdReady), 32'd0);
    checkOutput("reset.rspValid", 32'(rspValid), 32'd0);
    checkOutput("reset.rspData", 32'(rspData), 32'd0);
    checkOutput("reset.regWriteEnable", 32'(regWriteEnable), 32'd0);
    checkOutput("reset.regReadAddr", 32'(regReadAddr), 32'd0);
    checkOutput("reset.regDataIn", 32'(regDataIn), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    checkOutput("release.cmdReadyLow", 32'(cmdReady), 32'd0);
    @(posedge clk); #1;
    checkOutput("release.cmdReadyHigh", 32'(cmdReady), 32'd1);

    applyStimulus("write2", 2'b01, 2'd2, 2'd0, 8'hA5, 2, 8'hA5, 1);
    checkOutput("write2.reg2", 32'(regs[2]), 32'hA5);
    applyStimulus("read2", 2'b00, 2'd2, 2'd0, 8'h00, 2, 8'hA5, 0);

    // Stalled READ with another command waiting on cmdValid
    cmdValid = 1'b1; cmdOp = 2'b00; cmdAddrA = 2'd2; cmdAddrB = 2'd0; cmdData = 8'h00;
    @(posedge clk); #1;
    cmdOp = 2'b01; cmdAddrA = 2'd0; cmdData = 8'h5A;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("stall.rspValidRise", 32'(rspValid), 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      checkOutput("stall.rspValid", 32'(rspValid), 32'd1);
      checkOutput("stall.rspData", 32'(rspData), 32'hA5);
      checkOutput("stall.cmdReady", 32'(cmdReady), 32'd0);
    end
    rspReady = 1'b1;
    checkOutput("stall.cmdReadyAtHandshake", 32'(cmdReady), 32'd0);
    @(posedge clk); #1;
    rspReady = 1'b0;
    checkOutput("stall.rspValidAfter", 32'(rspValid), 32'd0);
    checkOutput("stall.cmdReadyAfter", 32'(cmdReady), 32'd1);
    cmdValid = 1'b0;
    @(posedge clk); #1;
    checkOutput("stall.noAccept", 32'(cmdReady), 32'd1);
    checkOutput("stall.reg0Untouched", 32'(regs[0]), 32'h00);

    applyStimulus("write0", 2'b01, 2'd0, 2'd0, 8'hF0, 2, 8'hF0, 1);
    applyStimulus("copy03", 2'b10, 2'd0, 2'd3, 8'h00, 3, 8'hF0, 1);
    checkOutput("copy03.reg3", 32'(regs[3]), 32'hF0);
    checkOutput("copy03.reg0", 32'(regs[0]), 32'hF0);

    applyStimulus("write1", 2'b01, 2'd1, 2'd0, 8'h11, 2, 8'h11, 1);
    applyStimulus("write2b", 2'b01, 2'd2, 2'd0, 8'h22, 2, 8'h22, 1);
    applyStimulus("swap12", 2'b11, 2'd1, 2'd2, 8'h00, 5, 8'h11, 2);
    checkOutput("swap12.reg1", 32'(regs[1]), 32'h22);
    checkOutput("swap12.reg2", 32'(regs[2]), 32'h11);

    applyStimulus("write3", 2'b01, 2'd3, 2'd0, 8'hFC, 2, 8'hFC, 1);
    applyStimulus("swap33", 2'b11, 2'd3, 2'd3, 8'h00, 5, 8'hFC, 2);
    checkOutput("swap33.reg3", 32'(regs[3]), 32'hFC);
    applyStimulus("copy11", 2'b10, 2'd1, 2'd1, 8'h00, 3, 8'h22, 1);
    checkOutput("copy11.reg1", 32'(regs[1]), 32'h22);

    // Reset asserted during WR_A of a SWAP 1<->2
    applyStimulus("write1r", 2'b01, 2'd1, 2'd0, 8'h11, 2, 8'h11, 1);
    applyStimulus("write2r", 2'b01, 2'd2, 2'd0, 8'h22, 2, 8'h22, 1);
    cmdValid = 1'b1; cmdOp = 2'b11; cmdAddrA = 2'd1; cmdAddrB = 2'd2;
    @(posedge clk); #1;
    cmdValid = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    checkOutput("abort.inWrA", 32'(regWriteEnable), 32'd1);
    checkOutput("abort.wrAddrA", 32'(regWriteAddr), 32'd1);
    checkOutput("abort.wrDataB", 32'(regDataIn), 32'h22);
    clr = 1'b0;
    #1;
    checkOutput("abort.regWriteEnable", 32'(regWriteEnable), 32'd0);
    checkOutput("abort.rspValid", 32'(rspValid), 32'd0);
    checkOutput("abort.cmdReady", 32'(cmdReady), 32'd0);
    @(posedge clk); #1;
    clr = 1'b1;
    @(posedge clk); #1;
    checkOutput("abort.cmdReadyBack", 32'(cmdReady), 32'd1);
    checkOutput("abort.reg2", 32'(regs[2]), 32'h22);
    checkOutput("abort.reg1", 32'(regs[1]), 32'h11);
    applyStimulus("readAfterAbort", 2'b00, 2'd2, 2'd0, 8'h00, 2, 8'h22, 0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
